// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready stream multiplexer with a registered output.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise select picks the channel.
module stream_mux #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [$clog2(NUM_CH)-1:0]    select,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_CH)-1:0]    out_channel
);

    localparam int SEL_W = $clog2(NUM_CH);

    logic                  load_ok;
    logic                  grant_ok;
    logic [SEL_W-1:0]      grant;
    logic                  grant_valid;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  xfer;

    assign load_ok = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] rr_last;
    logic             unused_select;

    assign unused_select = ^select;

    // Pick the first valid channel after the last winner, wrapping around.
    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grant_ok = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_last) + k) % NUM_CH;
            if (!grant_ok && in_valid[SEL_W'(idx)]) begin
                grant_ok = 1'b1;
                grant    = SEL_W'(idx);
            end
        end
    end

    // Remember the last winner so the next search starts just past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            rr_last <= grant;
        end
    end
`else
    // Fixed mode: the grant is the requested channel if it exists.
    always_comb begin
        grant    = select;
        grant_ok = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (select == SEL_W'(k)) begin
                grant_ok = 1'b1;
            end
        end
    end
`endif

    // Route the granted channel's word/valid and raise its ready only.
    always_comb begin
        grant_data  = '0;
        grant_valid = 1'b0;
        in_ready    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                grant_valid = in_valid[k];
                in_ready[k] = grant_ok && load_ok && !reset;
            end
        end
    end

    assign xfer = grant_ok && grant_valid && load_ok && !reset;

    // Output register: load on transfer, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else if (xfer) begin
            out_valid   <= 1'b1;
            out_data    <= grant_data;
            out_channel <= grant;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
